// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx
// Rate-1/2, K=3 convolutional encoder for the transmit side of the Viterbi
// link. It takes a frame of FRAME_LEN information bits, then appends two zero
// tail bits so the trellis ends in state 00. It emits one 2-bit code symbol
// per input or tail bit through a single-entry output register with
// backpressure.
//
// Parameters
//   FRAME_LEN : information bits per frame (1..255)
//   G0        : generator for o_code_bits[1]; bit2=u(n), bit1=u(n-1), bit0=u(n-2)
//   G1        : generator for o_code_bits[0]; same tap ordering
//
// Ports
//   i_clk, i_rst  : clock; asynchronous active-high reset
//   i_start       : opens a frame (honoured only in IDLE)
//   i_data_valid  : i_data_bit holds a valid bit
//   i_data_bit    : information bit u(n)
//   o_data_ready  : encoder accepts i_data_bit this cycle
//   o_code_valid  : o_code_bits holds a symbol
//   o_code_bits   : [1]=G0 parity, [0]=G1 parity
//   i_code_ready  : downstream accepts the symbol
//   o_sym_last    : marks the final tail symbol of the frame
//   o_busy        : high in every state except IDLE
//   o_frame_done  : one-cycle pulse after the last symbol is accepted
module conv_encoder_tx #(
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [2:0]  G0        = 3'b111,
  parameter logic [2:0]  G1        = 3'b101
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_data_valid,
  input  logic       i_data_bit,
  output logic       o_data_ready,
  output logic       o_code_valid,
  output logic [1:0] o_code_bits,
  input  logic       i_code_ready,
  output logic       o_sym_last,
  output logic       o_busy,
  output logic       o_frame_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t     state;
  logic [1:0] sr;        // {u(n-1), u(n-2)}
  logic [7:0] bit_cnt;   // information bits accepted so far
  logic       tail_cnt;  // tail symbols produced so far (0 or 1)
  logic       free;
  logic       accept;
  logic       sym_out;

  function automatic logic [1:0] encode(input logic u, input logic [1:0] s);
    logic [2:0] w;
    w = {u, s};
    return {^(w & G0), ^(w & G1)};
  endfunction

  // The output register can take a new symbol when it is empty or its
  // current symbol is being consumed on this edge.
  assign free         = !o_code_valid | i_code_ready;
  assign o_data_ready = (state == DATA) & free;
  assign accept       = i_data_valid & o_data_ready;
  assign sym_out      = o_code_valid & i_code_ready;
  assign o_busy       = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      sr           <= '0;
      bit_cnt      <= '0;
      tail_cnt     <= 1'b0;
      o_code_valid <= 1'b0;
      o_code_bits  <= '0;
      o_sym_last   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state    <= DATA;
            sr       <= '0;
            bit_cnt  <= '0;
            tail_cnt <= 1'b0;
          end
        end

        DATA: begin
          if (accept) begin
            o_code_bits  <= encode(i_data_bit, sr);
            o_code_valid <= 1'b1;
            o_sym_last   <= 1'b0;
            sr           <= {i_data_bit, sr[1]};
            bit_cnt      <= bit_cnt + 8'd1;
            if (bit_cnt == LAST_IDX) begin
              state <= TAIL;
            end
          end else if (sym_out) begin
            o_code_valid <= 1'b0;
          end
        end

        TAIL: begin
          // A zero is shifted in each time the output register frees up;
          // the second such symbol carries o_sym_last.
          if (free) begin
            o_code_bits  <= encode(1'b0, sr);
            o_code_valid <= 1'b1;
            o_sym_last   <= tail_cnt;
            sr           <= {1'b0, sr[1]};
            tail_cnt     <= 1'b1;
            if (tail_cnt) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (sym_out) begin
            o_code_valid <= 1'b0;
            o_sym_last   <= 1'b0;
            o_frame_done <= 1'b1;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Scoreboard bench for conv_encoder_tx. Expected symbols come from
// hand-encoded tables and are queued when a frame is issued; monitors pop and
// compare on every output handshake. Instance a uses FRAME_LEN=4 and
// instance b uses FRAME_LEN=8.
module tb_conv_encoder_tx;

  logic       clk = 1'b0;
  logic       rst;

  logic       start, dvalid, dbit, cready;
  logic       dready, cvalid, last, busy, fdone;
  logic [1:0] cbits;

  logic       start8, dvalid8, dbit8, cready8;
  logic       dready8, cvalid8, last8, busy8, fdone8;
  logic [1:0] cbits8;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_cnt8 = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by a test

  logic [2:0] sb[$];
  logic [2:0] sb8[$];
  logic [2:0] exp_a, exp_b;

  always #5 clk = ~clk;

  conv_encoder_tx #(.FRAME_LEN(4), .G0(3'b111), .G1(3'b101)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_data_valid(dvalid), .i_data_bit(dbit), .o_data_ready(dready),
    .o_code_valid(cvalid), .o_code_bits(cbits), .i_code_ready(cready),
    .o_sym_last(last), .o_busy(busy), .o_frame_done(fdone)
  );

  conv_encoder_tx #(.FRAME_LEN(8), .G0(3'b111), .G1(3'b101)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start8),
    .i_data_valid(dvalid8), .i_data_bit(dbit8), .o_data_ready(dready8),
    .o_code_valid(cvalid8), .o_code_bits(cbits8), .i_code_ready(cready8),
    .o_sym_last(last8), .o_busy(busy8), .o_frame_done(fdone8)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitors: compare {bits,last} on each output handshake.
  always @(negedge clk) begin
    if (!rst && cvalid && cready) begin
      if (sb.size() == 0) begin
        fail_now("sym_a_unexpected");
      end else begin
        exp_a = sb.pop_front();
        chk("sym_a", int'({cbits, last}), int'(exp_a));
      end
    end
    if (!rst && fdone) done_cnt++;
  end

  always @(negedge clk) begin
    if (!rst && cvalid8 && cready8) begin
      if (sb8.size() == 0) begin
        fail_now("sym_b_unexpected");
      end else begin
        exp_b = sb8.pop_front();
        chk("sym_b", int'({cbits8, last8}), int'(exp_b));
      end
    end
    if (!rst && fdone8) done_cnt8++;
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) cready = 1'b1;
    else if (ready_mode == 1) cready = 1'($urandom_range(0, 1));
  end

  // Drive n bits, MSB (bits[3]) first; glitch pulses i_start during DATA.
  task automatic drive_bits(input logic [3:0] bits, input int n,
                            input bit rnd, input bit glitch);
    int guard;
    bit acc;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      acc = 1'b0;
      dbit = bits[3-i];
      while (!acc) begin
        dvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start = glitch && (i == 1);
        @(negedge clk);
        acc = dvalid && dready;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard++;
        if (guard > 300) begin
          fail_now("drive_timeout");
          dvalid = 1'b0;
          return;
        end
      end
    end
    dvalid = 1'b0;
  endtask

  // syms holds six hand-encoded symbols, first one in [11:10].
  task automatic run_frame(input logic [3:0] bits, input logic [11:0] syms,
                           input bit rnd, input bit glitch);
    int base;
    for (int i = 0; i < 6; i++) sb.push_back({syms[11-2*i -: 2], 1'(i == 5)});
    base = done_cnt;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    drive_bits(bits, 4, rnd, glitch);
    if (glitch) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < 300; k++) begin
      if (done_cnt != base) break;
      @(posedge clk); #1;
    end
    chk("frame_done_seen", int'(done_cnt != base), 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("frame_done_once", done_cnt - base, 1);
    chk("busy_idle", int'(busy), 0);
    chk("sb_a_empty", sb.size(), 0);
  endtask

  task automatic run8(input logic val, input logic [19:0] syms);
    int base;
    for (int i = 0; i < 10; i++) sb8.push_back({syms[19-2*i -: 2], 1'(i == 9)});
    base = done_cnt8;
    @(posedge clk); #1; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    dbit8 = val;
    dvalid8 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (done_cnt8 != base) break;
      @(posedge clk); #1;
    end
    dvalid8 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("len8_done_once", done_cnt8 - base, 1);
    chk("len8_busy_idle", int'(busy8), 0);
    chk("sb_b_empty", sb8.size(), 0);
  endtask

  task automatic hold_proc();
    int guard;
    guard = 0;
    while (!(cvalid && cbits == 2'b10) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) fail_now("hold_sym2_timeout");
    cready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_bits", int'(cbits), 2);
      chk("hold_valid", int'(cvalid), 1);
      chk("hold_last", int'(last), 0);
      chk("hold_dready", int'(dready), 0);
      @(posedge clk); #1;
    end
    cready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(cvalid), 0);
    chk({tag, "_bits"},  int'(cbits), 0);
    chk({tag, "_last"},  int'(last), 0);
    chk({tag, "_dready"}, int'(dready), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(fdone), 0);
  endtask

  logic [3:0]  pat_bits[4];
  logic [11:0] pat_syms[4];

  initial begin
    pat_bits[0] = 4'b1011; pat_syms[0] = 12'b11_10_00_01_01_11;
    pat_bits[1] = 4'b0000; pat_syms[1] = 12'b00_00_00_00_00_00;
    pat_bits[2] = 4'b1111; pat_syms[2] = 12'b11_01_10_10_01_11;
    pat_bits[3] = 4'b0110; pat_syms[3] = 12'b00_11_01_01_11_00;

    rst = 1'b1;
    start = 1'b0; dvalid = 1'b0; dbit = 1'b0; cready = 1'b1;
    start8 = 1'b0; dvalid8 = 1'b0; dbit8 = 1'b0; cready8 = 1'b1;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_b_valid", int'(cvalid8), 0);
    chk("reset_b_busy", int'(busy8), 0);
    @(posedge clk); #1; rst = 1'b0;

    // Back-to-back frame 1,0,1,1
    run_frame(pat_bits[0], pat_syms[0], 1'b0, 1'b0);

    // Same frame, downstream stalls three cycles on the 2nd symbol
    ready_mode = 2;
    fork
      run_frame(pat_bits[0], pat_syms[0], 1'b0, 1'b0);
      hold_proc();
    join
    ready_mode = 0;

    // FRAME_LEN=8 all-zero and all-one frames
    run8(1'b0, 20'b0);
    run8(1'b1, 20'b11_01_10_10_10_10_10_10_01_11);

    // Reset in the middle of DATA after two symbols, then a clean frame
    sb.push_back({2'b11, 1'b0});
    sb.push_back({2'b10, 1'b0});
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    drive_bits(4'b1011, 2, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("rst_pre_syms", sb.size(), 0);
    chk("rst_pre_busy", int'(busy), 1);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("midrst");
    end
    @(posedge clk); #1; rst = 1'b0;
    sb.delete();
    run_frame(pat_bits[0], pat_syms[0], 1'b0, 1'b0);

    // i_start pulsed during DATA and TAIL must be ignored
    run_frame(pat_bits[3], pat_syms[3], 1'b0, 1'b1);

    // Random valid gaps and random downstream throttling
    ready_mode = 1;
    for (int f = 0; f < 20; f++) begin
      run_frame(pat_bits[f % 4], pat_syms[f % 4], 1'b1, 1'b0);
    end
    ready_mode = 0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_encoder_tx.md
Name: conv_encoder_tx

Overview:
- Rate-1/2, constraint-length K=3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder.
- Generators: G0=111 (octal 7), G1=101 (octal 5). The 4-state trellis matches the decoder's 2-bit path-metric datapath.
- Accepts a frame of FRAME_LEN information bits over a valid/ready input, then appends K-1=2 zero tail bits so the trellis terminates in state 00.
- Emits one 2-bit code symbol per accepted or tail bit over a valid/ready output with backpressure.

Parameters:
- FRAME_LEN, 8: information bits per frame; legal range 1..255.
- G0, 3'b111: generator polynomial for o_code_bits[1]. Bit 2 taps u(n), bit 1 taps u(n-1), bit 0 taps u(n-2).
- G1, 3'b101: generator polynomial for o_code_bits[0]. Same tap ordering.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  pulse that opens a frame; honoured only in IDLE.
- i_data_valid  in  1  i_data_bit is valid.
- i_data_bit  in  1  information bit u(n).
- o_data_ready  out  1  encoder accepts i_data_bit this cycle.
- o_code_valid  out  1  o_code_bits holds a symbol.
- o_code_bits  out  2  code symbol; [1]=G0 parity, [0]=G1 parity.
- i_code_ready  in  1  downstream accepts the symbol.
- o_sym_last  out  1  qualifies the final tail symbol of the frame.
- o_busy  out  1  high in every state except IDLE.
- o_frame_done  out  1  one-cycle pulse after the last symbol is accepted.

Behaviour:
- Reset (async assert; deassertion sampled at i_clk):
  - State goes to IDLE; shift register {u(n-1),u(n-2)} = 00; bit and tail counters = 0.
  - o_code_valid, o_code_bits, o_sym_last, o_data_ready, o_busy and o_frame_done are all 0.
  - Reset mid-frame discards the frame and any pending symbol without further handshakes.
- FSM states: IDLE, DATA, TAIL, DONE.
  - IDLE -> DATA on i_start. Shift register and counters clear on this edge.
  - DATA -> TAIL on the edge that accepts bit number FRAME_LEN.
  - TAIL -> DONE on the edge that loads the 2nd tail symbol into the output register.
  - DONE -> IDLE on the edge where the last symbol handshakes (o_code_valid & i_code_ready).
  - o_frame_done pulses in the cycle after that edge.
  - i_start outside IDLE is ignored.
- Output register: a single-entry skid stage. "Free" = !o_code_valid | i_code_ready.
- Input handshake:
  - o_data_ready = (state==DATA) & free. It is combinational from state and i_code_ready.
  - A bit is accepted when i_data_valid & o_data_ready.
  - When accepted, on the same edge:
    - o_code_bits[1] = ^({u,u(n-1),u(n-2)} & G0)
    - o_code_bits[0] = ^({u,u(n-1),u(n-2)} & G1)
    - o_code_valid is set to 1.
    - The shift register becomes {u,u(n-1)}.
  - Latency: the symbol is visible 1 cycle after acceptance.
- Tail: in TAIL, each cycle that "free" is high, encode u=0 the same way. Exactly 2 tail symbols are produced.
  - o_sym_last = 1 together with the 2nd tail symbol only.
- Backpressure:
  - While o_code_valid & !i_code_ready, o_code_bits and o_sym_last hold stable, and no input is accepted or tail generated.
  - A simultaneous handshake-out and accept-in sustains 1 symbol per cycle.
- When a symbol handshakes and no new symbol is loaded on that edge, o_code_valid clears.
- The end-of-frame state is always 00 after the tail. The shift register is cleared to 00 on i_start regardless.
- Throughput: FRAME_LEN+2 symbols per frame. The minimum frame period is FRAME_LEN+4 cycles, counting start, data, tail, DONE->IDLE and done.

Test Plan:
- FRAME_LEN=4, i_start, then bits 1,0,1,1 back-to-back with i_code_ready=1 -> symbols 11,10,00,01,01,11. o_sym_last only on the 6th. o_frame_done pulses once. o_busy then drops.
- Same frame with i_code_ready=0 for 3 cycles after the 2nd symbol -> 10 held stable, o_data_ready=0 for those 3 cycles. The sequence is unchanged afterwards.
- FRAME_LEN=8, all-zero data -> ten symbols 00. All-one data -> 11,01,10,10,10,10,10,10,01,11.
- i_data_valid toggled randomly and i_code_ready randomly throttled over 20 frames -> output matches a reference-model trellis encode bit-exactly. No symbol is dropped or duplicated.
- i_rst asserted mid-DATA after 2 symbols, then a new frame 1,0,1,1 -> outputs 0 during reset. The new frame yields 11,10,00,01,01,11, so no stale shift-register state is carried over.
- i_start pulsed during DATA and TAIL -> ignored. The frame completes with exactly FRAME_LEN+2 symbols and a single o_frame_done.
